// File: rtl/pulse_stretcher_pkg.sv
// Shared types and board defaults for the pulse stretcher.
// State encoding matches the other 2-bit FSMs in this codebase.
package pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HIGH = 2'b01,
        ST_GAP  = 2'b10
    } state_e;

    // Display-board defaults: 4-cycle flash, 2-cycle minimum dark gap.
    localparam int unsigned DISPLAY_HOLD_CYCLES = 4;
    localparam int unsigned DISPLAY_GAP_CYCLES  = 2;
    localparam int unsigned DISPLAY_CNT_W       = 16;

    // Counter reload value for a phase lasting 'cycles' clocks; 0 for an absent phase.
    function automatic int unsigned load_value(input int unsigned cycles);
        return (cycles == 0) ? 0 : cycles - 1;
    endfunction

endpackage

// File: rtl/load_down_counter.sv
// Loadable down counter shared by the HIGH and GAP phases.
// Saturates at zero; load has priority over decrement.
module load_down_counter
    import pulse_stretcher_pkg::*;
#(
    parameter int unsigned CNT_W = DISPLAY_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero_c
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle ticks into HOLD_CYCLES-long high levels separated
// by at least GAP_CYCLES low cycles; busy ticks are retriggered or queued one-deep.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = DISPLAY_HOLD_CYCLES,
    parameter int unsigned GAP_CYCLES  = DISPLAY_GAP_CYCLES,
    parameter bit          RETRIGGER   = 1'b0,
    parameter int unsigned CNT_W       = DISPLAY_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    output logic level,
    output logic busy,
    output logic overrun
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(load_value(HOLD_CYCLES));
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(load_value(GAP_CYCLES));

    state_e           state;
    state_e           state_nxt;
    logic             pending;
    logic             pending_nxt;
    logic             overrun_nxt;
    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_load_val;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;

    load_down_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .zero_c   (cnt_zero)
    );

    // Next state; a queued tick fills the empty slot, a tick hitting a full slot is dropped.
    always_comb begin
        state_nxt    = state;
        pending_nxt  = pending;
        overrun_nxt  = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = HOLD_LOAD;

        case (state)
            ST_IDLE: begin
                if (tick) begin
                    state_nxt = ST_HIGH;
                    cnt_load  = 1'b1;
                end
            end

            ST_HIGH: begin
                if (RETRIGGER && tick) begin
                    cnt_load = 1'b1;
                end else if (!cnt_zero) begin
                    cnt_dec     = 1'b1;
                    pending_nxt = pending | tick;
                    overrun_nxt = pending & tick;
                end else if (GAP_CYCLES != 0) begin
                    state_nxt    = ST_GAP;
                    cnt_load     = 1'b1;
                    cnt_load_val = GAP_LOAD;
                    pending_nxt  = pending | tick;
                    overrun_nxt  = pending & tick;
                end else if (pending || tick) begin
                    // Zero gap: chain straight into the next high period.
                    cnt_load    = 1'b1;
                    pending_nxt = 1'b0;
                    overrun_nxt = pending & tick;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end

            ST_GAP: begin
                if (!cnt_zero) begin
                    cnt_dec     = 1'b1;
                    pending_nxt = pending | tick;
                    overrun_nxt = pending & tick;
                end else if (pending || tick) begin
                    state_nxt   = ST_HIGH;
                    cnt_load    = 1'b1;
                    pending_nxt = 1'b0;
                    overrun_nxt = pending & tick;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt   = ST_IDLE;
                pending_nxt = 1'b0;
            end
        endcase
    end

    // State, queue slot and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            pending <= 1'b0;
            level   <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            level   <= (state_nxt == ST_HIGH);
            busy    <= (state_nxt != ST_IDLE);
            overrun <= overrun_nxt;
        end
    end

    // Every phase ends on a zero count, so an idle stretcher always holds zero.
    idle_cnt_clear: assert property (@(posedge clk) disable iff (rst)
        (state == ST_IDLE) |-> (cnt == '0));

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: three configurations (queue, retrigger, zero gap)
// share one tick stream and are checked against an interval-based model.
module tb_pulse_stretcher;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic [2:0] level;
    logic [2:0] busy;
    logic [2:0] overrun;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: each instance is described by its current high window [hs,he]
    // and the end of its busy window ge, plus a one-deep pending flag.
    int       gap_cfg [3] = '{2, 2, 0};
    bit       rt_cfg  [3] = '{1'b0, 1'b1, 1'b0};
    int       hs [3];
    int       he [3];
    int       ge [3];
    bit       pend [3];
    bit       ovr [3];
    logic [2:0] exp_o [3];

    always #5 clk = ~clk;

    pulse_stretcher #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .RETRIGGER(1'b0), .CNT_W(16)) dut_q (
        .clk(clk), .rst(rst), .tick(tick),
        .level(level[0]), .busy(busy[0]), .overrun(overrun[0]));

    pulse_stretcher #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .RETRIGGER(1'b1), .CNT_W(16)) dut_r (
        .clk(clk), .rst(rst), .tick(tick),
        .level(level[1]), .busy(busy[1]), .overrun(overrun[1]));

    pulse_stretcher #(.HOLD_CYCLES(4), .GAP_CYCLES(0), .RETRIGGER(1'b0), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .tick(tick),
        .level(level[2]), .busy(busy[2]), .overrun(overrun[2]));

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            hs[i] = -100; he[i] = -100; ge[i] = -100;
            pend[i] = 1'b0; ovr[i] = 1'b0;
            exp_o[i] = 3'b000;
        end
    endtask

    task automatic model_start(input int i, input int c);
        hs[i] = c + 1;
        he[i] = c + HOLD;
        ge[i] = c + HOLD + gap_cfg[i];
    endtask

    // Advance model for a tick (or not) present during cycle c; expectations are for cycle c+1.
    task automatic model_step(input bit t, input int c);
        for (int i = 0; i < 3; i++) begin
            bit in_high, in_gap, last;
            in_high = (hs[i] <= c) && (c <= he[i]);
            in_gap  = (he[i] < c) && (c <= ge[i]);
            last    = (in_high && c == he[i] && gap_cfg[i] == 0) || (in_gap && c == ge[i]);
            ovr[i]  = 1'b0;
            if (!in_high && !in_gap) begin
                if (t) model_start(i, c);
            end else if (in_high && rt_cfg[i] && t) begin
                he[i] = c + HOLD;
                ge[i] = he[i] + gap_cfg[i];
            end else if (last) begin
                if (pend[i] || t) model_start(i, c);
                ovr[i]  = pend[i] && t;
                pend[i] = 1'b0;
            end else if (t) begin
                if (pend[i]) ovr[i] = 1'b1;
                else         pend[i] = 1'b1;
            end
            exp_o[i] = {(hs[i] <= c + 1) && (c + 1 <= he[i]),
                        (hs[i] <= c + 1) && (c + 1 <= ge[i]),
                        ovr[i]};
        end
    endtask

    task automatic step(input bit t);
        tick = t;
        @(posedge clk);
        #1;
        model_step(t, cyc);
        cyc++;
        tick = 1'b0;
    endtask

    task automatic do_reset();
        tick = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1 model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 cyc = 0;
    endtask

    task automatic test_reset();
        tick = 1'b0;
        #2 rst = 1'b1;
        #1 model_reset();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({level[i], busy[i], overrun[i]} !== 3'b000) begin
                errors++;
                $display("FAIL reset_state inst%0d l/b/o got %b expected 000", i, {level[i], busy[i], overrun[i]});
            end
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 cyc = 0;
        for (int c = 0; c < 4; c++) begin
            step(1'b0);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if ({level[i], busy[i], overrun[i]} !== 3'b000) begin
                    errors++;
                    $display("FAIL reset_idle inst%0d cycle %0d l/b/o got %b expected 000", i, c + 1, {level[i], busy[i], overrun[i]});
                end
            end
        end
    endtask

    task automatic test_single_tick();
        do_reset();
        for (int c = 0; c < 22; c++) begin
            step(c == 10);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if ({level[i], busy[i], overrun[i]} !== exp_o[i]) begin
                    errors++;
                    $display("FAIL single_model inst%0d cycle %0d l/b/o got %b expected %b", i, c + 1, {level[i], busy[i], overrun[i]}, exp_o[i]);
                end
            end
            checks++;
            if ({level[0], busy[0], overrun[0]} !== {c + 1 >= 11 && c + 1 <= 14, c + 1 >= 11 && c + 1 <= 16, 1'b0}) begin
                errors++;
                $display("FAIL single_plan cycle %0d l/b/o got %b", c + 1, {level[0], busy[0], overrun[0]});
            end
        end
    endtask

    task automatic test_retrigger();
        do_reset();
        for (int c = 0; c < 22; c++) begin
            step(c == 10 || c == 12);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if ({level[i], busy[i], overrun[i]} !== exp_o[i]) begin
                    errors++;
                    $display("FAIL retrigger_model inst%0d cycle %0d l/b/o got %b expected %b", i, c + 1, {level[i], busy[i], overrun[i]}, exp_o[i]);
                end
            end
            checks++;
            if ({level[1], busy[1], overrun[1]} !== {c + 1 >= 11 && c + 1 <= 16, c + 1 >= 11 && c + 1 <= 18, 1'b0}) begin
                errors++;
                $display("FAIL retrigger_plan cycle %0d l/b/o got %b", c + 1, {level[1], busy[1], overrun[1]});
            end
        end
    endtask

    task automatic test_queue_overrun();
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            for (int c = 0; c < 24; c++) begin
                step(c == 10 || c == 12 || (pass == 1 && c == 13));
                for (int i = 0; i < 3; i++) begin
                    checks++;
                    if ({level[i], busy[i], overrun[i]} !== exp_o[i]) begin
                        errors++;
                        $display("FAIL queue_model pass%0d inst%0d cycle %0d l/b/o got %b expected %b", pass, i, c + 1, {level[i], busy[i], overrun[i]}, exp_o[i]);
                    end
                end
                checks++;
                if ({level[0], overrun[0]} !== {(c + 1 >= 11 && c + 1 <= 14) || (c + 1 >= 17 && c + 1 <= 20),
                                                pass == 1 && c + 1 == 14}) begin
                    errors++;
                    $display("FAIL queue_plan pass%0d cycle %0d level/overrun got %b", pass, c + 1, {level[0], overrun[0]});
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int c = 0; c < 22; c++) begin
            step(c == 10 || c == 11);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if ({level[i], busy[i], overrun[i]} !== exp_o[i]) begin
                    errors++;
                    $display("FAIL b2b_model inst%0d cycle %0d l/b/o got %b expected %b", i, c + 1, {level[i], busy[i], overrun[i]}, exp_o[i]);
                end
            end
            checks++;
            if ({level[2], busy[2], overrun[2]} !== {c + 1 >= 11 && c + 1 <= 18, c + 1 >= 11 && c + 1 <= 18, 1'b0}) begin
                errors++;
                $display("FAIL b2b_plan cycle %0d l/b/o got %b", c + 1, {level[2], busy[2], overrun[2]});
            end
        end
    endtask

    task automatic test_reset_mid_pulse();
        do_reset();
        for (int c = 0; c < 12; c++) step(c == 10);
        checks++;
        if (level[0] !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre level got %b expected 1", level[0]);
        end
        #3 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({level[i], busy[i], overrun[i]} !== 3'b000) begin
                errors++;
                $display("FAIL midreset_async inst%0d l/b/o got %b expected 000", i, {level[i], busy[i], overrun[i]});
            end
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 cyc = 16;
        for (int c = 16; c < 28; c++) begin
            step(c == 20);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if ({level[i], busy[i], overrun[i]} !== exp_o[i]) begin
                    errors++;
                    $display("FAIL midreset_model inst%0d cycle %0d l/b/o got %b expected %b", i, c + 1, {level[i], busy[i], overrun[i]}, exp_o[i]);
                end
            end
            checks++;
            if (level[0] !== (c + 1 >= 21 && c + 1 <= 24)) begin
                errors++;
                $display("FAIL midreset_plan cycle %0d level got %b", c + 1, level[0]);
            end
        end
    endtask

    task automatic test_random();
        int density [3] = '{10, 40, 85};
        for (int seg = 0; seg < 3; seg++) begin
            do_reset();
            for (int c = 0; c < 600; c++) begin
                step($urandom_range(0, 99) < density[seg]);
                for (int i = 0; i < 3; i++) begin
                    checks++;
                    if ({level[i], busy[i], overrun[i]} !== exp_o[i]) begin
                        errors++;
                        $display("FAIL random_model seg%0d inst%0d cycle %0d l/b/o got %b expected %b", seg, i, c + 1, {level[i], busy[i], overrun[i]}, exp_o[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_tick();
        test_retrigger();
        test_queue_overrun();
        test_back_to_back();
        test_reset_mid_pulse();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
Converts single-cycle ticks (e.g. from the keypad edge detector) into a level held high for a fixed number of clock cycles. It drives LEDs, display blanking and other slow consumers that cannot observe a one-cycle pulse. A programmable low gap separates consecutive output pulses. Ticks arriving while busy are either retriggered or queued one-deep, selected by parameter; ticks that cannot be queued are flagged.

Parameters:
HOLD_CYCLES, 4, cycles the output level stays high per accepted tick; must be >= 1
GAP_CYCLES, 2, minimum low cycles after a high period before the next high period; 0 allowed
RETRIGGER, 0, 1 = tick during high period restarts the hold count; 0 = tick is queued one-deep
CNT_W, 16, counter width; must satisfy 2^CNT_W > max(HOLD_CYCLES, GAP_CYCLES)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
tick  input  1  single-cycle request pulse, synchronous to clk
level  output  1  stretched pulse, registered
busy  output  1  high whenever state != IDLE, registered
overrun  output  1  one-cycle pulse: a tick was dropped, registered

Behaviour:
- Reset (async, active-high): state=IDLE, cnt=0, pending=0, level=0, busy=0, overrun=0. Takes effect immediately, including mid-pulse.
- States: IDLE, HIGH, GAP. level = (state==HIGH); busy = (state!=IDLE). Both are registered with the state.
- Latency: tick sampled at edge k -> level high for cycles k+1 .. k+HOLD_CYCLES, i.e. exactly HOLD_CYCLES cycles.
- IDLE: tick -> HIGH, cnt=HOLD_CYCLES-1. No tick -> stay IDLE.
- HIGH, cnt>0: cnt decrements each cycle.
- HIGH, cnt==0 (last high cycle):
  - GAP_CYCLES>0 -> GAP, cnt=GAP_CYCLES-1.
  - GAP_CYCLES==0 and (pending or tick) -> HIGH, cnt=HOLD_CYCLES-1, pending cleared. Level stays continuously high.
  - Otherwise -> IDLE.
- Tick in HIGH, RETRIGGER=1: cnt reloads to HOLD_CYCLES-1, including on the cnt==0 cycle. Level then ends HOLD_CYCLES cycles after the last tick. No pending, no overrun.
- Tick in HIGH, RETRIGGER=0: if pending==0, set pending. If pending==1, the tick is dropped and overrun=1 on the next cycle.
- GAP: level=0, cnt decrements. Tick follows the same pending/overrun rule as RETRIGGER=0 HIGH, regardless of RETRIGGER.
- GAP, cnt==0: pending or tick -> HIGH, cnt=HOLD_CYCLES-1, pending cleared. Otherwise -> IDLE.
- Simultaneous events: a tick on the cycle that consumes pending, when pending==1, is dropped and raises overrun. A tick on the cycle that consumes an empty pending slot is accepted directly.
- overrun is a one-cycle pulse, never sticky. Two consecutive dropped ticks produce two consecutive overrun cycles.
- Counter arithmetic is unsigned, CNT_W bits, and never wraps: decrement only when cnt>0.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'b00, HIGH=2'b01, GAP=2'b10), in the same style as the existing 2-bit FSM encodings;
  - a default HOLD/GAP constant set for the display board.
- One sub-module is natural: load_down_counter (load, load_val, dec, cnt, zero flag), instantiated once and shared by HIGH and GAP.
- The FSM, pending flag and overrun register stay in pulse_stretcher.

Test Plan:
- Single tick: HOLD=4, GAP=2, tick at cycle 10 -> level=1 cycles 11-14; busy=1 cycles 11-16; busy=0 from 17; overrun never asserted.
- Retrigger: RETRIGGER=1, HOLD=4, GAP=2, ticks at 10 and 12 -> level=1 cycles 11-16 continuously; GAP 17-18; idle 19.
- Queue: RETRIGGER=0, HOLD=4, GAP=2, ticks at 10 and 12 -> level 11-14, low 15-16, high 17-20; no overrun.
- Overrun: RETRIGGER=0, HOLD=4, GAP=2, ticks at 10, 12 and 13 -> overrun=1 only at cycle 14; level waveform identical to the queue case.
- Back-to-back: GAP=0, RETRIGGER=0, HOLD=4, ticks at 10 and 11 -> level=1 cycles 11-18 unbroken; busy drops at 19.
- Reset mid-pulse: tick at 10, rst asserted asynchronously mid-cycle 12 -> level, busy and overrun go 0 immediately. After release, an idle tick at 20 -> level 21-24.
